// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with multi-beat line refill,
// per-set round-robin replacement, flush and saturating hit/miss counters.
module icache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SET_W = (SETS > 1) ? IDX_W : 1;
    localparam int LSB   = OFF_W + 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              live;
    logic              flush_pend;
    logic              use_rr;
    logic [OFF_W-1:0]  cnt;
    logic [WAY_W-1:0]  victim;
    logic [31:0]       line_word;

    logic [WAYS-1:0]   valid  [SETS];
    logic [WAY_W-1:0]  rr_ptr [SETS];
    logic [TAG_W-1:0]  tags   [WAYS][SETS];
    logic [31:0]       data   [WAYS][SETS][LINE_WORDS];

    logic [OFF_W-1:0]  off;
    logic [SET_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              last;
    logic              fill;
    logic              unused_bits;

    assign off  = addr[LSB-1:2];
    assign idx  = SET_W'(addr[ADDR_W-1:LSB]) & SET_W'(SETS - 1);
    assign tag  = addr[ADDR_W-1 -: TAG_W];
    assign last = (cnt == OFF_W'(LINE_WORDS - 1));
    assign fill = (state == REFILL) && mem_rvalid;
    assign unused_bits = ^{addr[1:0], req_addr[1:0]};

    // A pending or live flush blocks acceptance until the valid bits clear.
    assign req_ready = (state == IDLE) && live && !flush && !flush_pend;

    logic             hit;
    logic             any_inv;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx][w] && tags[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data[victim][idx][cnt] <= mem_rdata;
            if (last) tags[victim][idx] <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            live       <= 1'b0;
            flush_pend <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            victim     <= '0;
            use_rr     <= 1'b0;
            line_word  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            live       <= 1'b1;
            resp_valid <= 1'b0;
            if (flush && state != IDLE) flush_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        for (int s = 0; s < SETS; s++) valid[s] <= '0;
                        flush_pend <= 1'b0;
                    end else if (req_valid && req_ready) begin
                        addr  <= req_addr;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_data  <= data[hit_way][idx][off];
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                        state <= IDLE;
                    end else begin
                        victim   <= any_inv ? inv_way : rr_ptr[idx];
                        use_rr   <= !any_inv;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr[ADDR_W-1:LSB], {LSB{1'b0}}};
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                        cnt   <= '0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        if (cnt == off) line_word <= mem_rdata;
                        if (last) begin
                            valid[idx][victim] <= !(flush_pend || flush);
                            if (use_rr) begin
                                rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1))
                                             ? '0 : rr_ptr[idx] + 1'b1;
                            end
                            mem_req <= 1'b0;
                            state   <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_data  <= line_word;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: refill, hits, RR eviction, stalls,
// flush during refill, reset mid-refill and counter saturation.
module tb_icache_assoc;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] r_data;
    logic [31:0] r_maddr;
    int          r_edges;
    bit          r_miss;
    bit          r_hold_ok;

    icache_assoc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h8) return 32'hA0 + {29'b0, a[4:2]};
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One fetch; serves refill beats with optional stall, flush or reset.
    task automatic fetch(input logic [31:0] a, input int stall_at,
                         input int stall_len, input int flush_at,
                         input int rst_at);
        int n;
        int beat;
        int stl;
        bit got;
        bit stalling;
        n = 0; beat = 0; stl = 0; got = 0;
        r_miss = 0; r_hold_ok = 1; r_edges = 0;
        r_data = '0; r_maddr = '0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_edges = 1;
        while (!got && rst_n && r_edges < 100) begin
            flush = 1'b0;
            mem_rvalid = 1'b0;
            stalling = 0;
            if (mem_req) begin
                r_miss  = 1;
                r_maddr = mem_addr;
                if (beat == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    break;
                end
                if (beat == stall_at && stl < stall_len) begin
                    stl++;
                    stalling = 1;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(mem_addr + 32'(beat * 4));
                    if (beat == flush_at) flush = 1'b1;
                    beat++;
                end
            end
            @(posedge clk); #1;
            r_edges++;
            if (stalling && (!mem_req || resp_valid)) r_hold_ok = 0;
            if (resp_valid) begin
                got = 1;
                r_data = resp_data;
            end
        end
        flush = 1'b0;
        mem_rvalid = 1'b0;
        if (!got && rst_n) check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
        flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // cold miss then hit within the same line
        fetch(32'h100, -1, 0, -1, -1);
        check("t1_miss", {31'b0, r_miss}, 32'd1);
        check("t1_mem_addr", r_maddr, 32'h100);
        check("t1_data", r_data, 32'hA0);
        check("t1_miss_lat", r_edges, 32'd11);
        check("t1_miss_cnt", miss_cnt, 32'd1);
        @(posedge clk); #1;
        check("t1_pulse", {31'b0, resp_valid}, 32'd0);
        fetch(32'h10C, -1, 0, -1, -1);
        check("t1_hit", {31'b0, r_miss}, 32'd0);
        check("t1_hit_data", r_data, 32'hA3);
        check("t1_hit_lat", r_edges, 32'd2);
        check("t1_hit_cnt", hit_cnt, 32'd1);

        // flush in idle, then three lines into set 0
        flush = 1'b1;
        #1;
        check("flush_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        fetch(32'h000, -1, 0, -1, -1);
        check("t2_a_data", r_data, 32'hC0DE0000);
        fetch(32'h080, -1, 0, -1, -1);
        check("t2_b_miss", {31'b0, r_miss}, 32'd1);
        fetch(32'h100, -1, 0, -1, -1);
        check("t2_c_miss", {31'b0, r_miss}, 32'd1);
        check("t2_c_data", r_data, 32'hA0);
        fetch(32'h080, -1, 0, -1, -1);
        check("t2_b_hit", {31'b0, r_miss}, 32'd0);
        check("t2_b_data", r_data, 32'hC0DE0080);
        fetch(32'h000, -1, 0, -1, -1);
        check("t2_a_evicted", {31'b0, r_miss}, 32'd1);
        check("t2_miss_cnt", miss_cnt, 32'd5);

        // five-cycle beat stall mid-refill
        fetch(32'h044, 3, 5, -1, -1);
        check("t3_hold", {31'b0, r_hold_ok}, 32'd1);
        check("t3_mem_addr", r_maddr, 32'h040);
        check("t3_data", r_data, 32'hC0DE0044);
        check("t3_lat", r_edges, 32'd16);
        fetch(32'h05C, -1, 0, -1, -1);
        check("t3_hit", {31'b0, r_miss}, 32'd0);
        check("t3_hit_data", r_data, 32'hC0DE005C);

        // flush during refill
        fetch(32'h200, -1, 0, 2, -1);
        check("t4_data", r_data, 32'hC0DE0200);
        check("t4_pend_ready", {31'b0, req_ready}, 32'd0);
        fetch(32'h200, -1, 0, -1, -1);
        check("t4_refetch_miss", {31'b0, r_miss}, 32'd1);
        fetch(32'h05C, -1, 0, -1, -1);
        check("t4_old_miss", {31'b0, r_miss}, 32'd1);
        check("t4_miss_cnt", miss_cnt, 32'd9);
        check("t4_hit_cnt", hit_cnt, 32'd3);

        // reset on beat 3
        fetch(32'h300, -1, 0, -1, 3);
        check("t5_mem_req", {31'b0, mem_req}, 32'd0);
        check("t5_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("t5_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_miss_cnt_rst", miss_cnt, 32'd0);
        fetch(32'h300, -1, 0, -1, -1);
        check("t5_miss", {31'b0, r_miss}, 32'd1);
        check("t5_data", r_data, 32'hC0DE0300);

        // saturation of the hit counter
        force dut.hit_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt;
        @(posedge clk); #1;
        fetch(32'h304, -1, 0, -1, -1);
        check("t6_hit", {31'b0, r_miss}, 32'd0);
        check("t6_data", r_data, 32'hC0DE0304);
        check("t6_sat", hit_cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
